// File: rtl/fft_bfly_if.sv
// Handshake and memory-address bus between the FFT butterfly scheduler and the datapath.
// master = scheduler side, slave = datapath / sample-memory side.
interface fft_bfly_if #(
  parameter int N_LOG2 = 5,
  parameter int ADDR_W = N_LOG2,
  parameter int TW_W   = N_LOG2 - 1,
  parameter int ST_W   = 3
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ST_W-1:0]   stage;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [TW_W-1:0]   tw_idx;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [ADDR_W-1:0] wr_addr_b;

  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_bfly_scheduler.sv
// Address/twiddle sequencer for an in-place iterative radix-2 DIT FFT.
// Walks every stage and butterfly, issues operand reads, and echoes them as write-backs one cycle later.
module fft_bfly_scheduler #(
  parameter int N_LOG2 = 5,
  parameter int ADDR_W = N_LOG2,
  parameter int TW_W   = N_LOG2 - 1,
  parameter int ST_W   = 3
) (
  input  logic       clk,
  input  logic       rst,
  fft_bfly_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ST_W-1:0] LAST_ST = ST_W'(N_LOG2 - 1);

  state_t            state, nxt_state;
  logic [ST_W-1:0]   stage_q, nxt_stage;
  logic [TW_W-1:0]   b_q, nxt_b;
  logic [ADDR_W-1:0] half, pos, nxt_a, nxt_bb;
  logic [TW_W-1:0]   nxt_tw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      stage_q <= '0;
      b_q     <= '0;
    end else begin
      state   <= nxt_state;
      stage_q <= nxt_stage;
      b_q     <= nxt_b;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_stage = stage_q;
    nxt_b     = b_q;
    unique case (state)
      IDLE: begin
        nxt_stage = '0;
        nxt_b     = '0;
        if (bus.start) nxt_state = RUN;
      end
      RUN: begin
        if (b_q == '1) nxt_state = DRAIN;
        else           nxt_b     = b_q + 1'b1;
      end
      DRAIN: begin
        nxt_b = '0;
        if (stage_q == LAST_ST) begin
          nxt_state = DONE;
        end else begin
          nxt_state = RUN;
          nxt_stage = stage_q + 1'b1;
        end
      end
      DONE: begin
        nxt_state = IDLE;
        nxt_stage = '0;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Addresses are computed for the butterfly about to be read so they can be registered with rd_en.
  assign half   = ADDR_W'(1) << nxt_stage;
  assign pos    = ADDR_W'(nxt_b) & (half - 1'b1);
  assign nxt_a  = ((ADDR_W'(nxt_b) >> nxt_stage) << (nxt_stage + 1'b1)) | pos;
  assign nxt_bb = nxt_a + half;
  assign nxt_tw = TW_W'(pos) << (LAST_ST - nxt_stage);

  assign bus.stage = stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr_a <= '0;
      bus.rd_addr_b <= '0;
      bus.tw_idx    <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr_a <= '0;
      bus.wr_addr_b <= '0;
    end else begin
      bus.busy      <= (nxt_state == RUN) || (nxt_state == DRAIN);
      bus.done      <= (nxt_state == DONE);
      bus.rd_en     <= (nxt_state == RUN);
      bus.rd_addr_a <= (nxt_state == RUN) ? nxt_a  : '0;
      bus.rd_addr_b <= (nxt_state == RUN) ? nxt_bb : '0;
      bus.tw_idx    <= (nxt_state == RUN) ? nxt_tw : '0;
      // Datapath is combinational from read port to write port, so the write trails the read by one cycle.
      bus.wr_en     <= bus.rd_en;
      bus.wr_addr_a <= bus.rd_addr_a;
      bus.wr_addr_b <= bus.rd_addr_b;
    end
  end
endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Randomized check of fft_bfly_scheduler against a cycle-indexed schedule model.
module tb_fft_bfly_scheduler;
  localparam int N_LOG2 = 5;
  localparam int N      = 1 << N_LOG2;
  localparam int HB     = N / 2;
  localparam int P      = HB + 1;
  localparam int TOTAL  = N_LOG2 * P + 1;
  localparam int ADDR_W = N_LOG2;
  localparam int TW_W   = N_LOG2 - 1;
  localparam int ST_W   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_bfly_if #(.N_LOG2(N_LOG2), .ADDR_W(ADDR_W), .TW_W(TW_W), .ST_W(ST_W)) bus ();

  fft_bfly_scheduler #(.N_LOG2(N_LOG2), .ADDR_W(ADDR_W), .TW_W(TW_W), .ST_W(ST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp, n_bad;
  int ph;            // cycle index since start was sampled; -1 while idle
  int nrd, nwr;
  int wcnt [N_LOG2][N];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (ph=%0d, t=%0t)", tag, got, exp, ph, $time);
    end
  endtask

  // Read issued at schedule cycle p, derived from the stage/butterfly timing rules.
  function automatic void rd_at(input int p, output bit en, output int s,
                                output int a, output int bb, output int tw);
    int k, b, half, grp, pos;
    en = 1'b0; s = 0; a = 0; bb = 0; tw = 0;
    if (p >= 1 && p <= TOTAL - 1) begin
      k = p - 1;
      s = k / P;
      b = k % P;
      if (b < HB) begin
        en   = 1'b1;
        half = 1 << s;
        grp  = b / half;
        pos  = b % half;
        a    = grp * 2 * half + pos;
        bb   = a + half;
        tw   = pos * (1 << (N_LOG2 - 1 - s));
      end
    end
  endfunction

  task automatic clr_sb();
    nrd = 0;
    nwr = 0;
    for (int s = 0; s < N_LOG2; s++)
      for (int a = 0; a < N; a++) wcnt[s][a] = 0;
  endtask

  task automatic cyc();
    bit re, we;
    int s, a, bb, tw, ws, wa, wb, wt, sb;
    @(posedge clk);
    if (rst)              ph = -1;
    else if (ph < 0)      ph = bus.start ? 1 : -1;
    else if (ph == TOTAL) ph = -1;
    else                  ph++;
    if (ph <= 1) clr_sb();
    @(negedge clk);
    rd_at(ph, re, s, a, bb, tw);
    rd_at(ph - 1, we, ws, wa, wb, wt);
    chk("busy",   int'(bus.busy),      int'(ph >= 1 && ph <= TOTAL - 1));
    chk("done",   int'(bus.done),      int'(ph == TOTAL));
    chk("rd_en",  int'(bus.rd_en),     int'(re));
    chk("rd_a",   int'(bus.rd_addr_a), a);
    chk("rd_b",   int'(bus.rd_addr_b), bb);
    chk("tw_idx", int'(bus.tw_idx),    tw);
    chk("wr_en",  int'(bus.wr_en),     int'(we));
    chk("wr_a",   int'(bus.wr_addr_a), wa);
    chk("wr_b",   int'(bus.wr_addr_b), wb);
    if (ph >= 1 && ph <= TOTAL - 1) chk("stage", int'(bus.stage), s);
    else if (ph < 0)                chk("stage_idle", int'(bus.stage), 0);
    // fixed points of the 32-point schedule
    if (ph >= 1 && ph <= 4) chk("s0_rd_a", int'(bus.rd_addr_a), 2 * (ph - 1));
    if (ph >= 2 && ph <= 5) chk("s0_wr_b", int'(bus.wr_addr_b), 2 * (ph - 2) + 1);
    if (ph == 1 + 2 * P + 5) begin
      chk("s2b5_a", int'(bus.rd_addr_a), 9);
      chk("s2b5_b", int'(bus.rd_addr_b), 13);
      chk("s2b5_tw", int'(bus.tw_idx), 4);
    end
    if (ph == 1 + 4 * P + 15) begin
      chk("s4b15_a", int'(bus.rd_addr_a), 15);
      chk("s4b15_b", int'(bus.rd_addr_b), 31);
      chk("s4b15_tw", int'(bus.tw_idx), 15);
    end
    if (ph == 1 + 3 * P) chk("s3b0_b", int'(bus.rd_addr_b), 8);
    if (bus.rd_en) nrd++;
    if (bus.wr_en) begin
      nwr++;
      wcnt[ws][bus.wr_addr_a]++;
      wcnt[ws][bus.wr_addr_b]++;
    end
    if (ph == TOTAL) begin
      chk("n_rd", nrd, N_LOG2 * HB);
      chk("n_wr", nwr, N_LOG2 * HB);
      sb = 0;
      for (int i = 0; i < N_LOG2; i++)
        for (int j = 0; j < N; j++) if (wcnt[i][j] != 1) sb++;
      chk("wr_once", sb, 0);
    end
  endtask

  // Runs n cycles with occasional start pulses while the block is not idle.
  task automatic run_noisy(input int n);
    for (int i = 0; i < n; i++) begin
      bus.start = (ph >= 1) && ($urandom_range(0, 3) == 0);
      cyc();
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int lim;
    lim = 0;
    while (ph >= 0 && lim < 200) begin
      cyc();
      lim++;
    end
    chk("idle_reached", int'(ph < 0), 1);
  endtask

  initial begin
    int gap, rcyc;
    n_cmp = 0; n_bad = 0; ph = -1;
    clr_sb();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (20) cyc();

    // single start pulse, noise during the run must be ignored
    bus.start = 1'b1;
    cyc();
    run_noisy(TOTAL + 2);
    wait_idle();

    // start held high: back-to-back transforms
    bus.start = 1'b1;
    repeat (2 * (TOTAL + 1) + 5) cyc();
    bus.start = 1'b0;
    wait_idle();
    repeat (3) cyc();

    // reset on cycle 40, then a clean restart
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (39) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    bus.start = 1'b1;
    cyc();
    run_noisy(TOTAL + 2);
    wait_idle();

    // random gaps, random mid-run resets
    for (int it = 0; it < 6; it++) begin
      gap = $urandom_range(0, 5);
      repeat (gap) cyc();
      bus.start = 1'b1;
      cyc();
      if ($urandom_range(0, 1) == 1) begin
        rcyc = $urandom_range(1, TOTAL);
        run_noisy(rcyc - 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end else begin
        run_noisy(TOTAL + 1);
      end
      wait_idle();
    end
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
